dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl_if.sv | 24 ++
 rtl/dmem_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between a load/store unit and dmem_ctrl.
// The master issues accesses; the controller (slave) reports completion.
interface dmem_ctrl_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, we, size, uns, addr, wdata,
        input  busy, done, err, rdata
    );

    modport slave (
        input  req, we, size, uns, addr, wdata,
        output busy, done, err, rdata
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data memory controller: byte-addressed little-endian word array with
// a fixed number of wait states per access and misalignment/range checks.
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 32,
    parameter int LATENCY     = 2
) (
    input logic       clk,
    input logic       rst_n,
    dmem_ctrl_if.slave bus
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        c_we;
    logic [1:0]  c_size;
    logic        c_uns;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        err_q;
    logic [31:0] rdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [2:0]    nbytes;
    logic [3:0]    be;
    logic          bad;
    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic [31:0]   lane;
    logic [31:0]   ldata;
    logic [31:0]   wsh;
    logic          fire;

    assign bus.busy  = (state == S_WAIT);
    assign bus.done  = (state == S_DONE);
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

    assign fire = (state == S_WAIT) && (cnt == 4'd0);
    assign idx  = c_addr[AW+1:2];
    assign word = mem[idx];
    assign lane = word >> {c_addr[1:0], 3'b000};
    assign wsh  = c_wdata << {c_addr[1:0], 3'b000};

    always_comb begin
        nbytes = 3'd0;
        be     = 4'b0000;
        unique case (1'b1)
            (c_size == 2'b00): begin
                nbytes = 3'd1;
                be     = 4'b0001 << c_addr[1:0];
            end
            (c_size == 2'b01): begin
                nbytes = 3'd2;
                be     = 4'b0011 << {c_addr[1], 1'b0};
            end
            (c_size == 2'b10): begin
                nbytes = 3'd4;
                be     = 4'b1111;
            end
            default: ;
        endcase
    end

    // Range check is done in 33 bits so addresses near 2^32 cannot wrap.
    always_comb begin
        bad = (c_size == 2'b11)
            || ((c_size == 2'b01) && c_addr[0])
            || ((c_size == 2'b10) && (c_addr[1:0] != 2'b00))
            || (({1'b0, c_addr} + {30'b0, nbytes}) > LIMIT);
    end

    always_comb begin
        ldata = word;
        unique case (1'b1)
            (c_size == 2'b00):
                ldata = {{24{~c_uns & lane[7]}}, lane[7:0]};
            (c_size == 2'b01):
                ldata = {{16{~c_uns & lane[15]}}, lane[15:0]};
            default:
                ldata = word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (fire && c_we && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wsh[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            c_we    <= 1'b0;
            c_size  <= 2'b00;
            c_uns   <= 1'b0;
            c_addr  <= 32'd0;
            c_wdata <= 32'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.req) begin
                        c_we    <= bus.we;
                        c_size  <= bus.size;
                        c_uns   <= bus.uns;
                        c_addr  <= bus.addr;
                        c_wdata <= bus.wdata;
                        cnt     <= 4'(LATENCY);
                        state   <= S_WAIT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        err_q   <= bad;
                        rdata_q <= (bad || c_we) ? 32'd0 : ldata;
                        state   <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
